// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, issue FSM states and the default request record shared by
// the ALU issue stage and its request FIFO.
package alu_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int REQ_DATA_W = 64;
    localparam int REQ_TAG_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} issue_state_t;

    typedef struct packed {
        logic [1:0]            opcode;
        logic [REQ_DATA_W-1:0] in0;
        logic [REQ_DATA_W-1:0] in1;
        logic [REQ_TAG_W-1:0]  tag;
    } alu_req_t;
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: in-order request buffer, DEPTH entries of type T, with
// occupancy count; the caller guarantees no push when full or pop when empty.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter type T     = alu_req_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  T            i_data,
    input  logic        i_pop,
    output T            o_data,
    output logic [AW:0] o_count,
    output logic        o_full,
    output logic        o_empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == FULL_CNT;
    assign o_empty = r_count == '0;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests, issues them one at a time, waits ALU_LAT
// cycles for the result and returns it with its tag, strictly in request order.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = REQ_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = REQ_TAG_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_opcode,
    input  logic [DATA_W-1:0] i_req_in0,
    input  logic [DATA_W-1:0] i_req_in1,
    input  logic [TAG_W-1:0]  i_req_tag,
    output logic              o_alu_enable,
    output logic [1:0]        o_alu_opcode,
    output logic [DATA_W-1:0] o_alu_in0,
    output logic [DATA_W-1:0] o_alu_in1,
    input  logic [DATA_W:0]   i_alu_out,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W:0]   o_rsp_data,
    output logic [TAG_W-1:0]  o_rsp_tag,
    output logic              o_rsp_err
);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]        opcode;
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic [TAG_W-1:0]  tag;
    } req_t;

    issue_state_t   r_state;
    issue_state_t   w_nxt;
    logic [CW-1:0]  r_cnt;
    logic [TAG_W-1:0] r_tag;
    req_t           w_req;
    req_t           w_head;
    logic [AW:0]    w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_take;
    logic           w_rsvd;

    assign w_req       = '{opcode: i_req_opcode, in0: i_req_in0, in1: i_req_in1, tag: i_req_tag};
    assign o_req_ready = rst_n && !w_full;
    assign w_push      = i_req_valid && o_req_ready;
    assign w_rsvd      = w_head.opcode == OP_RSVD;

    alu_req_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_take),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A completed response hands straight over to the next queued op.
    always_comb begin
        w_take = !w_empty && (r_state == S_IDLE || (r_state == S_RESP && i_rsp_ready));
        w_nxt  = r_state;
        case (r_state)
            S_ISSUE: w_nxt = S_WAIT;
            S_WAIT:  w_nxt = r_cnt == '0 ? S_RESP : S_WAIT;
            S_RESP:  w_nxt = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_nxt = r_state;
        endcase
        if (w_take) w_nxt = w_rsvd ? S_RESP : S_ISSUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tag        <= '0;
            o_alu_enable <= 1'b0;
            o_alu_opcode <= '0;
            o_alu_in0    <= '0;
            o_alu_in1    <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
            o_rsp_tag    <= '0;
            o_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            o_alu_enable <= w_nxt == S_ISSUE;
            if (w_take && !w_rsvd) begin
                o_alu_opcode <= w_head.opcode;
                o_alu_in0    <= w_head.in0;
                o_alu_in1    <= w_head.in1;
                r_tag        <= w_head.tag;
            end
            if (r_state == S_ISSUE) r_cnt <= CW'(ALU_LAT - 1);
            if (r_state == S_WAIT) begin
                if (r_cnt == '0) begin
                    o_rsp_data  <= i_alu_out;
                    o_rsp_tag   <= r_tag;
                    o_rsp_err   <= 1'b0;
                    o_rsp_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if (r_state == S_RESP && i_rsp_ready) o_rsp_valid <= 1'b0;
            // Reserved ops answer immediately and override the handshake clear.
            if (w_take && w_rsvd) begin
                o_rsp_valid <= 1'b1;
                o_rsp_err   <= 1'b1;
                o_rsp_data  <= '0;
                o_rsp_tag   <= w_head.tag;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) w_count <= CNT_MAX);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenarios against alu_issue_ctrl driven by a
// behavioural ALU with ALU_LAT cycles of latency.
module tb_alu_issue_ctrl;
    import alu_pkg::*;
    localparam int DW = 64, TW = 4, DEPTH = 4, LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_opcode = '0;
    logic [DW-1:0] i_req_in0 = '0;
    logic [DW-1:0] i_req_in1 = '0;
    logic [TW-1:0] i_req_tag = '0;
    logic          o_alu_enable;
    logic [1:0]    o_alu_opcode;
    logic [DW-1:0] o_alu_in0;
    logic [DW-1:0] o_alu_in1;
    logic [DW:0]   i_alu_out;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW:0]   o_rsp_data;
    logic [TW-1:0] o_rsp_tag;
    logic          o_rsp_err;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_opcode(i_req_opcode),
        .i_req_in0(i_req_in0), .i_req_in1(i_req_in1), .i_req_tag(i_req_tag),
        .o_alu_enable(o_alu_enable), .o_alu_opcode(o_alu_opcode),
        .o_alu_in0(o_alu_in0), .o_alu_in1(o_alu_in1), .i_alu_out(i_alu_out),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_tag(o_rsp_tag), .o_rsp_err(o_rsp_err)
    );

    function automatic logic [DW:0] alu_f(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        logic [DW:0] xa, xb;
        xa = {a[DW-1], a};
        xb = {b[DW-1], b};
        return op == OP_ADD ? xa + xb : op == OP_SUB ? xa - xb : xa & xb;
    endfunction

    logic [DW:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= o_alu_enable ? alu_f(o_alu_opcode, o_alu_in0, o_alu_in1) : pipe[0];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign i_alu_out = pipe[LAT-1];

    always @(posedge clk) if (o_alu_enable) en_cnt++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
        logic acc;
        int k = 0;
        i_req_valid = 1'b1; i_req_opcode = op; i_req_in0 = a; i_req_in1 = b; i_req_tag = t;
        do begin
            acc = o_req_ready;
            step();
            k++;
        end while (!acc && k < 50);
        i_req_valid = 1'b0;
        n_vec++;
        if (!acc) begin n_err++; $display("FAIL send_accept tag=%0d req_ready got 0 exp 1", t); end
    endtask

    task automatic wait_rsp(input string nm);
        int k = 0;
        while (!o_rsp_valid && k < 30) begin step(); k++; end
        n_vec++;
        if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL %s_timeout rsp_valid got %b exp 1", nm, o_rsp_valid); end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_alu_enable, o_alu_opcode, o_alu_in0, o_alu_in1, o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err, o_req_ready} !== '0) begin
            n_err++; $display("FAIL reset_outputs some output nonzero: en=%b vld=%b rdy=%b data=%0h exp all 0", o_alu_enable, o_rsp_valid, o_req_ready, o_rsp_data);
        end
        step(); step();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", o_req_ready); end
        step();
    endtask

    task automatic test_add;
        int e0;
        i_rsp_ready = 1'b1;
        e0 = en_cnt;
        send(OP_ADD, 64'd32, 64'd16, 4'd3);
        step();
        n_vec++;
        if (o_alu_enable !== 1'b1) begin n_err++; $display("FAIL add_enable_on got %b exp 1", o_alu_enable); end
        step();
        n_vec++;
        if ({o_alu_enable, o_rsp_valid} !== 2'b00) begin n_err++; $display("FAIL add_wait en/vld got %b exp 00", {o_alu_enable, o_rsp_valid}); end
        step();
        n_vec++;
        if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_latency rsp_valid got %b exp 1", o_rsp_valid); end
        n_vec++;
        if (o_rsp_data !== 65'd48) begin n_err++; $display("FAIL add_data got %0d exp 48", o_rsp_data); end
        n_vec++;
        if (o_rsp_tag !== 4'd3 || o_rsp_err !== 1'b0) begin n_err++; $display("FAIL add_tag_err got tag=%0d err=%b exp tag=3 err=0", o_rsp_tag, o_rsp_err); end
        n_vec++;
        if (en_cnt - e0 !== 1) begin n_err++; $display("FAIL add_enable_pulses got %0d exp 1", en_cnt - e0); end
        step();
        n_vec++;
        if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_consumed rsp_valid got %b exp 0", o_rsp_valid); end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        i_rsp_ready = 1'b1;
        send(OP_SUB, 64'd32, 64'd16, 4'd1);
        send(OP_ADD, {DW{1'b1}}, {DW{1'b1}}, 4'd2);
        wait_rsp("b2b_first");
        n_vec++;
        if (o_rsp_data !== 65'd16 || o_rsp_tag !== 4'd1) begin n_err++; $display("FAIL b2b_first got data=%0h tag=%0d exp data=10 tag=1", o_rsp_data, o_rsp_tag); end
        do begin step(); k++; end while (!o_rsp_valid && k < 20);
        n_vec++;
        if (k !== 3) begin n_err++; $display("FAIL b2b_spacing got %0d cycles exp 3", k); end
        n_vec++;
        if (o_rsp_data !== 65'h1_FFFF_FFFF_FFFF_FFFE || o_rsp_tag !== 4'd2) begin
            n_err++; $display("FAIL b2b_second got data=%0h tag=%0d exp data=1fffffffffffffffe tag=2", o_rsp_data, o_rsp_tag);
        end
        step();
    endtask

    task automatic test_backpressure;
        logic rdy;
        int acc = 0;
        int got = 0;
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_req_opcode = OP_ADD; i_req_in0 = 64'(acc * 10); i_req_in1 = 64'd5; i_req_tag = TW'(acc);
            rdy = o_req_ready;
            step();
            if (rdy) acc++;
        end
        n_vec++;
        if (acc !== 5) begin n_err++; $display("FAIL bp_accepted got %0d exp 5", acc); end
        n_vec++;
        if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b exp 0", o_req_ready); end
        i_req_valid = 1'b0;
        n_vec++;
        if (o_rsp_valid !== 1'b1 || o_rsp_data !== 65'd5 || o_rsp_tag !== 4'd0) begin
            n_err++; $display("FAIL bp_stall got vld=%b data=%0d tag=%0d exp vld=1 data=5 tag=0", o_rsp_valid, o_rsp_data, o_rsp_tag);
        end
        step(); step(); step();
        n_vec++;
        if (o_rsp_valid !== 1'b1 || o_rsp_data !== 65'd5 || o_rsp_tag !== 4'd0) begin
            n_err++; $display("FAIL bp_hold got vld=%b data=%0d tag=%0d exp vld=1 data=5 tag=0", o_rsp_valid, o_rsp_data, o_rsp_tag);
        end
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (o_rsp_valid) begin
                n_vec++;
                if (o_rsp_tag !== TW'(got) || o_rsp_data !== 65'(got * 10 + 5)) begin
                    n_err++; $display("FAIL bp_drain%0d got data=%0d tag=%0d exp data=%0d tag=%0d", got, o_rsp_data, o_rsp_tag, got * 10 + 5, got);
                end
                got++;
            end
            step();
        end
        n_vec++;
        if (got !== 5) begin n_err++; $display("FAIL bp_drain_count got %0d exp 5", got); end
        n_vec++;
        if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b exp 1", o_req_ready); end
    endtask

    task automatic test_reserved;
        int e0;
        i_rsp_ready = 1'b1;
        e0 = en_cnt;
        send(OP_RSVD, 64'd5, 64'd6, 4'd7);
        step();
        n_vec++;
        if (o_rsp_valid !== 1'b1 || o_rsp_err !== 1'b1) begin n_err++; $display("FAIL rsvd_flags got vld=%b err=%b exp 1 1", o_rsp_valid, o_rsp_err); end
        n_vec++;
        if (o_rsp_data !== '0 || o_rsp_tag !== 4'd7) begin n_err++; $display("FAIL rsvd_payload got data=%0h tag=%0d exp data=0 tag=7", o_rsp_data, o_rsp_tag); end
        step();
        n_vec++;
        if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsvd_consumed rsp_valid got %b exp 0", o_rsp_valid); end
        step(); step(); step();
        n_vec++;
        if (en_cnt !== e0) begin n_err++; $display("FAIL rsvd_no_enable got %0d pulses exp 0", en_cnt - e0); end
    endtask

    task automatic test_and;
        i_rsp_ready = 1'b1;
        send(OP_AND, 64'd32, 64'd16, 4'd4);
        wait_rsp("and_a");
        n_vec++;
        if (o_rsp_data !== 65'd0 || o_rsp_tag !== 4'd4 || o_rsp_err !== 1'b0) begin
            n_err++; $display("FAIL and_disjoint got data=%0h tag=%0d err=%b exp 0 4 0", o_rsp_data, o_rsp_tag, o_rsp_err);
        end
        step();
        send(OP_AND, 64'hFF, 64'h0F, 4'd5);
        wait_rsp("and_b");
        n_vec++;
        if (o_rsp_data !== 65'h0F || o_rsp_tag !== 4'd5) begin n_err++; $display("FAIL and_mask got data=%0h tag=%0d exp f 5", o_rsp_data, o_rsp_tag); end
        step();
    endtask

    task automatic test_reset_mid_wait;
        int e0;
        logic seen = 1'b0;
        i_rsp_ready = 1'b1;
        send(OP_ADD, 64'd1, 64'd1, 4'd1);
        send(OP_ADD, 64'd2, 64'd2, 4'd2);
        send(OP_ADD, 64'd3, 64'd3, 4'd3);
        n_vec++;
        if (o_alu_enable !== 1'b0 || o_alu_in0 !== 64'd1 || o_rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL rstw_in_wait got en=%b in0=%0d vld=%b exp 0 1 0", o_alu_enable, o_alu_in0, o_rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_alu_enable, o_alu_opcode, o_alu_in0, o_alu_in1, o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err, o_req_ready} !== '0) begin
            n_err++; $display("FAIL rstw_outputs some output nonzero: en=%b in0=%0d vld=%b rdy=%b exp all 0", o_alu_enable, o_alu_in0, o_rsp_valid, o_req_ready);
        end
        step(); step();
        rst_n = 1'b1;
        e0 = en_cnt;
        for (int c = 0; c < 8; c++) begin step(); if (o_rsp_valid) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0 || en_cnt !== e0) begin n_err++; $display("FAIL rstw_dropped got rsp_seen=%b enables=%0d exp 0 0", seen, en_cnt - e0); end
        send(OP_ADD, 64'd5, 64'd7, 4'hA);
        wait_rsp("rstw_after");
        n_vec++;
        if (o_rsp_data !== 65'd12 || o_rsp_tag !== 4'hA || o_rsp_err !== 1'b0) begin
            n_err++; $display("FAIL rstw_after got data=%0d tag=%0h err=%b exp 12 a 0", o_rsp_data, o_rsp_tag, o_rsp_err);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_reserved();
        test_and();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 64-bit ALU. It accepts operation requests (opcode, two signed operands, tag) over a valid/ready handshake and buffers them in a small in-order FIFO. It drives the ALU's enable/opcode/in0/in1 one operation at a time and captures the 65-bit ALU result after a fixed latency. It returns each result with its tag over a valid/ready response port, in request order.

Parameters:
DATA_W, 64, operand width; the ALU result is DATA_W+1 bits.
DEPTH, 4, request FIFO entries (power of two, >=2).
TAG_W, 4, request/response tag width.
ALU_LAT, 1, cycles from the ALU sampling edge (enable=1) to a valid alu_out (>=1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  FIFO can accept.
req_opcode  in  2  00 ADD, 01 SUB, 10 AND, 11 reserved.
req_in0  in  DATA_W  signed operand 0.
req_in1  in  DATA_W  signed operand 1.
req_tag  in  TAG_W  request identifier, echoed on the response.
alu_enable  out  1  one-cycle ALU start strobe.
alu_opcode  out  2  ALU opcode.
alu_in0  out  DATA_W  ALU operand 0.
alu_in1  out  DATA_W  ALU operand 1.
alu_out  in  DATA_W+1  signed ALU result.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts.
rsp_data  out  DATA_W+1  captured result.
rsp_tag  out  TAG_W  tag of the op.
rsp_err  out  1  reserved opcode, op not executed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO emptied; state IDLE.
  - All outputs 0, except req_ready=1 once reset releases.
  - An in-flight op is dropped with no response.
- FIFO:
  - Push on req_valid&&req_ready.
  - req_ready = (count<DEPTH); it depends only on registered count, with no same-cycle pop bypass.
  - Pop occurs only on the transition into ISSUE or into the reserved-opcode response.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- All alu_* and rsp_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO non-empty, head opcode != 11: pop, load alu_opcode/in0/in1 from head, latch tag -> ISSUE.
  - IDLE, head opcode == 11: pop; rsp_valid=1, rsp_err=1, rsp_data=0, rsp_tag=head tag -> RESP (ALU untouched).
  - ISSUE: alu_enable=1 for exactly this cycle; the ALU samples on the closing edge -> WAIT with counter=ALU_LAT-1.
  - WAIT: alu_enable=0; alu_opcode/in0/in1 held stable. When counter==0, on that edge: rsp_data<=alu_out, rsp_tag<=latched tag, rsp_err<=0, rsp_valid<=1 -> RESP. Otherwise decrement the counter.
  - RESP: rsp_* held stable while rsp_valid && !rsp_ready.
  - RESP on handshake: rsp_valid<=0 -> IDLE. Exception: if the FIFO is non-empty, take the IDLE pop decision in the same cycle (goes directly to ISSUE or to a new RESP for a reserved op).
- Latency: request accepted at edge 0 into an empty, idle block:
  - ISSUE after edge 1.
  - rsp_valid=1 after edge 2+ALU_LAT.
  - Sustained throughput with rsp_ready=1: one op per 2+ALU_LAT cycles.
- Capacity: at most one op in flight plus DEPTH queued.
- Responses strictly in request order.
- rsp_data is passed through unchanged, with no truncation or sign handling.

Decomposition:
- Package alu_pkg:
  - OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_RSVD=2'b11.
  - Issue FSM state enum.
  - Request struct {opcode, in0, in1, tag}.
- One sub-module: alu_req_fifo, a parameterised DEPTH x request-struct synchronous FIFO with count, full and empty outputs.
- The FSM lives in alu_issue_ctrl.
- The bench uses a behavioural ALU model honouring ALU_LAT.

Test Plan:
1. ADD, in0=32, in1=16, tag=3, rsp_ready=1 -> alu_enable high for exactly 1 cycle; rsp_valid after edge 3; rsp_data=48, rsp_tag=3, rsp_err=0.
2. SUB 32-16 (tag 1) then ADD -1+-1 (tag 2), back-to-back -> rsp_data=16 (tag 1) then 65-bit -2 (tag 2), in order, 3 cycles apart.
3. Backpressure: rsp_ready=0, req_valid held with 6 requests -> exactly 5 accepted (1 in flight + 4 queued); req_ready=0 thereafter; rsp_data/rsp_tag stable while stalled; releasing rsp_ready drains all in order.
4. Reserved: opcode 11, tag 7 -> rsp_err=1, rsp_data=0, rsp_tag=7; alu_enable never asserted.
5. AND, 32 & 16 -> rsp_data=0; AND 0xFF & 0x0F -> 0x0F.
6. rst_n pulsed low mid-WAIT with 2 queued -> all outputs 0 immediately; no response produced; next request after release completes normally with tag echoed.
